// File: rtl/psw_datapath_if.sv
// psw_datapath_if: control/status bundle between the lock control FSM
// (master) and the password datapath (slave).
//
// Handshake semantics: key_valid qualifies key_digit for exactly the cycle it
// is high and has no ready/back-pressure; the datapath answers an accepted
// digit with a one-cycle input_valid pulse. All other controls are
// single-cycle strobes sampled at the rising edge of clk.
//
// Signals (master -> slave): key_valid, key_digit[3:0], decision, mem_sl,
//   buff_sl, mem_rst, buff_rst, err_inc, err_clr
// Signals (slave -> master): input_valid, limit, same, master_same,
//   error_num[3:0], mem_len[3:0], buff_len[3:0]
interface psw_datapath_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       decision;
  logic       mem_sl;
  logic       buff_sl;
  logic       mem_rst;
  logic       buff_rst;
  logic       err_inc;
  logic       err_clr;
  logic       input_valid;
  logic       limit;
  logic       same;
  logic       master_same;
  logic [3:0] error_num;
  logic [3:0] mem_len;
  logic [3:0] buff_len;

  modport master (
    output key_valid, key_digit, decision, mem_sl, buff_sl,
           mem_rst, buff_rst, err_inc, err_clr,
    input  input_valid, limit, same, master_same, error_num, mem_len, buff_len
  );

  modport slave (
    input  key_valid, key_digit, decision, mem_sl, buff_sl,
           mem_rst, buff_rst, err_inc, err_clr,
    output input_valid, limit, same, master_same, error_num, mem_len, buff_len
  );
endinterface

// File: rtl/psw_datapath.sv
// psw_datapath: password datapath for the door lock. Captures keypad digits
// into a pending register, appends them to the master password memory or the
// attempt buffer on command, and reports comparison/limit/error status to the
// control FSM. No FSM of its own; all state is plain registers.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - psw_datapath_if.slave (keypad strobe, store/clear/select strobes,
//          error strobes in; input_valid, limit, same, master_same,
//          error_num, mem_len, buff_len out)
module psw_datapath #(
  parameter int                          MAX_LEN    = 8,
  parameter int                          MIN_LEN    = 4,
  parameter int                          MASTER_LEN = 6,
  parameter logic [4*MASTER_LEN-1:0]     MASTER_PSW = 24'h314159
) (
  input logic           clk,
  input logic           rst,
  psw_datapath_if.slave bus
);

  localparam logic [3:0] MAX_L    = 4'(MAX_LEN);
  localparam logic [3:0] MIN_L    = 4'(MIN_LEN);
  localparam logic [3:0] MASTER_L = 4'(MASTER_LEN);
  // A master code longer than the buffer can never match; bound the compare.
  localparam int CMP_LEN = (MASTER_LEN < MAX_LEN) ? MASTER_LEN : MAX_LEN;

  logic [3:0] pend_q, pend_d;
  logic       input_valid_q, input_valid_d;
  logic [3:0] mem_q  [MAX_LEN];
  logic [3:0] mem_d  [MAX_LEN];
  logic [3:0] buff_q [MAX_LEN];
  logic [3:0] buff_d [MAX_LEN];
  logic [3:0] mem_len_q, mem_len_d;
  logic [3:0] buff_len_q, buff_len_d;
  logic [3:0] err_q, err_d;
  logic       slots_eq, master_eq;

  // Digit capture: non-decimal keys leave pend untouched and raise no pulse.
  always_comb begin
    pend_d        = pend_q;
    input_valid_d = 1'b0;
    if (bus.key_valid && (bus.key_digit <= 4'd9)) begin
      pend_d        = bus.key_digit;
      input_valid_d = 1'b1;
    end
  end

  // Memory: clear beats append; append is dropped once full.
  always_comb begin
    mem_d     = mem_q;
    mem_len_d = mem_len_q;
    if (bus.mem_rst) begin
      mem_len_d = 4'd0;
      for (int i = 0; i < MAX_LEN; i++) mem_d[i] = 4'd0;
    end else if (bus.mem_sl && (mem_len_q < MAX_L)) begin
      mem_len_d = mem_len_q + 4'd1;
      for (int i = 0; i < MAX_LEN; i++)
        if (4'(i) == mem_len_q) mem_d[i] = pend_q;
    end
  end

  // Buffer: same rules as memory, fully independent of it.
  always_comb begin
    buff_d     = buff_q;
    buff_len_d = buff_len_q;
    if (bus.buff_rst) begin
      buff_len_d = 4'd0;
      for (int i = 0; i < MAX_LEN; i++) buff_d[i] = 4'd0;
    end else if (bus.buff_sl && (buff_len_q < MAX_L)) begin
      buff_len_d = buff_len_q + 4'd1;
      for (int i = 0; i < MAX_LEN; i++)
        if (4'(i) == buff_len_q) buff_d[i] = pend_q;
    end
  end

  // Error counter: clear has priority, increment saturates at 15.
  always_comb begin
    err_d = err_q;
    if (bus.err_clr)                         err_d = 4'd0;
    else if (bus.err_inc && (err_q != 4'hF)) err_d = err_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q        <= 4'd0;
      input_valid_q <= 1'b0;
      mem_len_q     <= 4'd0;
      buff_len_q    <= 4'd0;
      err_q         <= 4'd0;
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_q[i]  <= 4'd0;
        buff_q[i] <= 4'd0;
      end
    end else begin
      pend_q        <= pend_d;
      input_valid_q <= input_valid_d;
      mem_len_q     <= mem_len_d;
      buff_len_q    <= buff_len_d;
      err_q         <= err_d;
      mem_q         <= mem_d;
      buff_q        <= buff_d;
    end
  end

  // Slot compares; slots at or above the memory length are masked.
  always_comb begin
    slots_eq = 1'b1;
    for (int i = 0; i < MAX_LEN; i++)
      if ((4'(i) < mem_len_q) && (mem_q[i] != buff_q[i])) slots_eq = 1'b0;
  end

  // Master code is stored first digit in the MSBs.
  always_comb begin
    master_eq = (MASTER_LEN <= MAX_LEN);
    for (int i = 0; i < CMP_LEN; i++)
      if (buff_q[i] != MASTER_PSW[4*(MASTER_LEN-1-i) +: 4]) master_eq = 1'b0;
  end

  assign bus.input_valid = input_valid_q;
  assign bus.limit       = bus.decision ? (mem_len_q == MAX_L) : (buff_len_q == MAX_L);
  assign bus.same        = (mem_len_q == buff_len_q) && (mem_len_q >= MIN_L) && slots_eq;
  assign bus.master_same = (buff_len_q == MASTER_L) && master_eq;
  assign bus.error_num   = err_q;
  assign bus.mem_len     = mem_len_q;
  assign bus.buff_len    = buff_len_q;

endmodule

// File: tb/tb_psw_datapath.sv
module tb_psw_datapath;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  psw_datapath_if bus ();

  psw_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    tick();
    bus.key_valid = 1'b0;
  endtask

  // Key at edge N, idle edge N+1, store strobe sampled at edge N+2.
  task automatic push(input logic [3:0] d, input logic to_mem);
    key(d);
    tick();
    if (to_mem) bus.mem_sl = 1'b1;
    else        bus.buff_sl = 1'b1;
    tick();
    bus.mem_sl  = 1'b0;
    bus.buff_sl = 1'b0;
  endtask

  task automatic clear(input logic do_mem, input logic do_buff);
    bus.mem_rst  = do_mem;
    bus.buff_rst = do_buff;
    tick();
    bus.mem_rst  = 1'b0;
    bus.buff_rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.key_valid = 1'b0; bus.key_digit = 4'd0; bus.decision = 1'b0;
    bus.mem_sl = 1'b0; bus.buff_sl = 1'b0; bus.mem_rst = 1'b0; bus.buff_rst = 1'b0;
    bus.err_inc = 1'b0; bus.err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.input_valid !== 1'b0) begin n_err++; $display("FAIL reset_input_valid: got %b expected 0", bus.input_valid); end
    n_cmp++; if (bus.mem_len !== 4'd0) begin n_err++; $display("FAIL reset_mem_len: got %0d expected 0", bus.mem_len); end
    n_cmp++; if (bus.buff_len !== 4'd0) begin n_err++; $display("FAIL reset_buff_len: got %0d expected 0", bus.buff_len); end
    n_cmp++; if (bus.error_num !== 4'd0) begin n_err++; $display("FAIL reset_error_num: got %0d expected 0", bus.error_num); end
    n_cmp++; if (bus.same !== 1'b0) begin n_err++; $display("FAIL reset_same: got %b expected 0", bus.same); end
    n_cmp++; if (bus.master_same !== 1'b0) begin n_err++; $display("FAIL reset_master_same: got %b expected 0", bus.master_same); end
    n_cmp++; if (bus.limit !== 1'b0) begin n_err++; $display("FAIL reset_limit_buff: got %b expected 0", bus.limit); end
    bus.decision = 1'b1; #1;
    n_cmp++; if (bus.limit !== 1'b0) begin n_err++; $display("FAIL reset_limit_mem: got %b expected 0", bus.limit); end
  endtask

  task automatic test_mem_write();
    bus.decision = 1'b1;
    key(4'd1);
    n_cmp++; if (bus.input_valid !== 1'b1) begin n_err++; $display("FAIL key_input_valid: got %b expected 1", bus.input_valid); end
    tick();
    n_cmp++; if (bus.input_valid !== 1'b0) begin n_err++; $display("FAIL key_input_valid_drop: got %b expected 0", bus.input_valid); end
    bus.mem_sl = 1'b1; tick(); bus.mem_sl = 1'b0;
    push(4'd2, 1'b1); push(4'd3, 1'b1); push(4'd4, 1'b1);
    n_cmp++; if (bus.mem_len !== 4'd4) begin n_err++; $display("FAIL mem_len_4: got %0d expected 4", bus.mem_len); end
    n_cmp++; if (bus.limit !== 1'b0) begin n_err++; $display("FAIL mem_limit_4: got %b expected 0", bus.limit); end
    n_cmp++; if (bus.buff_len !== 4'd0) begin n_err++; $display("FAIL buff_len_untouched: got %0d expected 0", bus.buff_len); end
  endtask

  task automatic test_same();
    clear(1'b0, 1'b1);
    push(4'd1, 1'b0); push(4'd2, 1'b0); push(4'd3, 1'b0);
    n_cmp++; if (bus.same !== 1'b0) begin n_err++; $display("FAIL same_len3: got %b expected 0", bus.same); end
    push(4'd4, 1'b0);
    n_cmp++; if (bus.same !== 1'b1) begin n_err++; $display("FAIL same_1234: got %b expected 1", bus.same); end
    n_cmp++; if (bus.buff_len !== 4'd4) begin n_err++; $display("FAIL buff_len_4: got %0d expected 4", bus.buff_len); end
    push(4'd9, 1'b0);
    n_cmp++; if (bus.same !== 1'b0) begin n_err++; $display("FAIL same_len5: got %b expected 0", bus.same); end
    n_cmp++; if (bus.buff_len !== 4'd5) begin n_err++; $display("FAIL buff_len_5: got %0d expected 5", bus.buff_len); end
  endtask

  task automatic test_limit();
    bus.decision = 1'b1;
    clear(1'b1, 1'b0);
    n_cmp++; if (bus.mem_len !== 4'd0) begin n_err++; $display("FAIL mem_rst_len: got %0d expected 0", bus.mem_len); end
    for (int i = 1; i <= 7; i++) push(4'(i), 1'b1);
    n_cmp++; if (bus.limit !== 1'b0) begin n_err++; $display("FAIL limit_at_7: got %b expected 0", bus.limit); end
    push(4'd8, 1'b1);
    n_cmp++; if (bus.limit !== 1'b1) begin n_err++; $display("FAIL limit_at_8: got %b expected 1", bus.limit); end
    n_cmp++; if (bus.mem_len !== 4'd8) begin n_err++; $display("FAIL mem_len_8: got %0d expected 8", bus.mem_len); end
    bus.decision = 1'b0; #1;
    n_cmp++; if (bus.limit !== 1'b0) begin n_err++; $display("FAIL limit_select_buff: got %b expected 0", bus.limit); end
    bus.decision = 1'b1;
    push(4'd7, 1'b1);
    n_cmp++; if (bus.mem_len !== 4'd8) begin n_err++; $display("FAIL mem_len_full_hold: got %0d expected 8", bus.mem_len); end
    clear(1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) push(4'(i), 1'b0);
    n_cmp++; if (bus.same !== 1'b1) begin n_err++; $display("FAIL same_full_no_overwrite: got %b expected 1", bus.same); end
    bus.decision = 1'b0; #1;
    n_cmp++; if (bus.limit !== 1'b1) begin n_err++; $display("FAIL limit_buff_full: got %b expected 1", bus.limit); end
    bus.mem_rst = 1'b1; bus.mem_sl = 1'b1; tick(); bus.mem_rst = 1'b0; bus.mem_sl = 1'b0;
    n_cmp++; if (bus.mem_len !== 4'd0) begin n_err++; $display("FAIL clear_beats_append: got %0d expected 0", bus.mem_len); end
    n_cmp++; if (bus.same !== 1'b0) begin n_err++; $display("FAIL same_after_clear: got %b expected 0", bus.same); end
    key(4'd6); tick();
    bus.mem_sl = 1'b1; bus.buff_rst = 1'b1; tick(); bus.mem_sl = 1'b0; bus.buff_rst = 1'b0;
    n_cmp++; if (bus.mem_len !== 4'd1) begin n_err++; $display("FAIL indep_mem_len: got %0d expected 1", bus.mem_len); end
    n_cmp++; if (bus.buff_len !== 4'd0) begin n_err++; $display("FAIL indep_buff_len: got %0d expected 0", bus.buff_len); end
  endtask

  task automatic test_master();
    clear(1'b0, 1'b1);
    push(4'd3, 1'b0); push(4'd1, 1'b0); push(4'd4, 1'b0);
    push(4'd1, 1'b0); push(4'd5, 1'b0); push(4'd9, 1'b0);
    n_cmp++; if (bus.master_same !== 1'b1) begin n_err++; $display("FAIL master_314159: got %b expected 1", bus.master_same); end
    n_cmp++; if (bus.buff_len !== 4'd6) begin n_err++; $display("FAIL master_buff_len: got %0d expected 6", bus.buff_len); end
    clear(1'b0, 1'b1);
    push(4'd3, 1'b0); push(4'd1, 1'b0); push(4'd4, 1'b0);
    push(4'd1, 1'b0); push(4'd5, 1'b0);
    n_cmp++; if (bus.master_same !== 1'b0) begin n_err++; $display("FAIL master_31415: got %b expected 0", bus.master_same); end
    push(4'd8, 1'b0);
    n_cmp++; if (bus.master_same !== 1'b0) begin n_err++; $display("FAIL master_314158: got %b expected 0", bus.master_same); end
  endtask

  task automatic test_error();
    bus.err_inc = 1'b1; tick(); bus.err_inc = 1'b0;
    n_cmp++; if (bus.error_num !== 4'd1) begin n_err++; $display("FAIL err_one: got %0d expected 1", bus.error_num); end
    bus.err_inc = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    bus.err_inc = 1'b0;
    n_cmp++; if (bus.error_num !== 4'd15) begin n_err++; $display("FAIL err_saturate: got %0d expected 15", bus.error_num); end
    bus.err_inc = 1'b1; bus.err_clr = 1'b1; tick(); bus.err_inc = 1'b0; bus.err_clr = 1'b0;
    n_cmp++; if (bus.error_num !== 4'd0) begin n_err++; $display("FAIL err_clr_priority: got %0d expected 0", bus.error_num); end
  endtask

  task automatic test_invalid_digit();
    clear(1'b1, 1'b1);
    push(4'd1, 1'b1); push(4'd2, 1'b1); push(4'd3, 1'b1); push(4'd4, 1'b1);
    push(4'd1, 1'b0); push(4'd2, 1'b0); push(4'd3, 1'b0);
    key(4'd4); tick();
    key(4'd12);
    n_cmp++; if (bus.input_valid !== 1'b0) begin n_err++; $display("FAIL digit12_input_valid: got %b expected 0", bus.input_valid); end
    bus.buff_sl = 1'b1; tick(); bus.buff_sl = 1'b0;
    n_cmp++; if (bus.same !== 1'b1) begin n_err++; $display("FAIL digit12_pend_held: got %b expected 1", bus.same); end
  endtask

  task automatic test_back_to_back();
    clear(1'b1, 1'b1);
    bus.key_valid = 1'b1; bus.key_digit = 4'd6; tick();
    n_cmp++; if (bus.input_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first: got %b expected 1", bus.input_valid); end
    bus.key_digit = 4'd7; tick();
    n_cmp++; if (bus.input_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second: got %b expected 1", bus.input_valid); end
    // Keys coincident with writes: each write takes the previously captured digit.
    bus.key_digit = 4'd5; bus.buff_sl = 1'b1; tick();
    n_cmp++; if (bus.buff_len !== 4'd1) begin n_err++; $display("FAIL coinc_len1: got %0d expected 1", bus.buff_len); end
    bus.key_digit = 4'd3; tick();
    n_cmp++; if (bus.input_valid !== 1'b1) begin n_err++; $display("FAIL coinc_input_valid: got %b expected 1", bus.input_valid); end
    bus.key_valid = 1'b0; tick();
    n_cmp++; if (bus.input_valid !== 1'b0) begin n_err++; $display("FAIL coinc_input_valid_drop: got %b expected 0", bus.input_valid); end
    tick();
    bus.buff_sl = 1'b0;
    n_cmp++; if (bus.buff_len !== 4'd4) begin n_err++; $display("FAIL coinc_len4: got %0d expected 4", bus.buff_len); end
    push(4'd7, 1'b1); push(4'd5, 1'b1); push(4'd3, 1'b1); push(4'd3, 1'b1);
    n_cmp++; if (bus.same !== 1'b1) begin n_err++; $display("FAIL coinc_order_7533: got %b expected 1", bus.same); end
  endtask

  task automatic test_async_reset();
    clear(1'b1, 1'b1);
    bus.decision = 1'b1;
    push(4'd5, 1'b1); push(4'd5, 1'b0);
    bus.err_inc = 1'b1; tick(); bus.err_inc = 1'b0;
    bus.key_valid = 1'b1; bus.key_digit = 4'd3; bus.mem_sl = 1'b1; tick();
    n_cmp++; if (bus.mem_len !== 4'd2) begin n_err++; $display("FAIL pre_rst_mem_len: got %0d expected 2", bus.mem_len); end
    n_cmp++; if (bus.input_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_input_valid: got %b expected 1", bus.input_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.mem_len !== 4'd0) begin n_err++; $display("FAIL arst_mem_len: got %0d expected 0", bus.mem_len); end
    n_cmp++; if (bus.buff_len !== 4'd0) begin n_err++; $display("FAIL arst_buff_len: got %0d expected 0", bus.buff_len); end
    n_cmp++; if (bus.error_num !== 4'd0) begin n_err++; $display("FAIL arst_error_num: got %0d expected 0", bus.error_num); end
    n_cmp++; if (bus.input_valid !== 1'b0) begin n_err++; $display("FAIL arst_input_valid: got %b expected 0", bus.input_valid); end
    n_cmp++; if (bus.limit !== 1'b0) begin n_err++; $display("FAIL arst_limit: got %b expected 0", bus.limit); end
    n_cmp++; if (bus.same !== 1'b0) begin n_err++; $display("FAIL arst_same: got %b expected 0", bus.same); end
    n_cmp++; if (bus.master_same !== 1'b0) begin n_err++; $display("FAIL arst_master_same: got %b expected 0", bus.master_same); end
    bus.key_valid = 1'b0; bus.mem_sl = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_mem_write();
    test_same();
    test_limit();
    test_master();
    test_error();
    test_invalid_digit();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
